// File: rtl/pkt_gen_task_drr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : pkt_gen_task_drr_arbiter
// Brief  : Byte-fair deficit-round-robin merge of per-engine task streams into
//          one registered task stream. Optional per-port byte counters are
//          enabled by defining PKT_GEN_TASK_DRR_ARBITER_STATS_EN.
// Rev    : 1.0
// ============================================================================
module pkt_gen_task_drr_arbiter #(
   parameter  int PORT_CNT       = 4,
   parameter  int FLOW_CNT_WIDTH = 4,
   parameter  int QUANTUM        = 1518,
   parameter  int DEFICIT_WIDTH  = 18,
   localparam int PORT_WIDTH     = (PORT_CNT == 1) ? 1 : $clog2(PORT_CNT)
) (
   input  logic                               clk_i,
   input  logic                               rst_i,
   input  logic [PORT_CNT*FLOW_CNT_WIDTH-1:0] in_flow_num_i,
   input  logic [PORT_CNT*16-1:0]             in_pkt_size_i,
   input  logic [PORT_CNT-1:0]                in_valid_i,
   output logic [PORT_CNT-1:0]                in_ready_o,
   output logic [PORT_WIDTH-1:0]              task_port_o,
   output logic [FLOW_CNT_WIDTH-1:0]          task_flow_num_o,
   output logic [15:0]                        task_pkt_size_o,
   output logic                               task_valid_o,
   input  logic                               task_ready_i
`ifdef PKT_GEN_TASK_DRR_ARBITER_STATS_EN
   ,
   input  logic [PORT_WIDTH-1:0]              stat_rd_port_i,
   output logic [31:0]                        stat_bytes_o,
   input  logic                               stat_clr_i
`endif
);

   typedef enum logic [1:0] {
      ST_VISIT = 2'd0,
      ST_SERVE = 2'd1,
      ST_SEND  = 2'd2
   } state_t;

   localparam logic [DEFICIT_WIDTH:0]  c_quantum   = (DEFICIT_WIDTH+1)'(QUANTUM);
   localparam logic [PORT_WIDTH-1:0]   c_last_port = PORT_WIDTH'(PORT_CNT - 1);

   state_t                     r_state;
   state_t                     w_state_nxt;
   logic [PORT_WIDTH-1:0]      r_cur_port;
   logic [DEFICIT_WIDTH-1:0]   r_deficit [PORT_CNT];

   logic                       w_sel_valid;
   logic [15:0]                w_sel_size;
   logic [FLOW_CNT_WIDTH-1:0]  w_sel_flow;
   logic [DEFICIT_WIDTH-1:0]   w_sel_deficit;
   logic [DEFICIT_WIDTH:0]     w_visit_sum;
   logic [DEFICIT_WIDTH-1:0]   w_visit_deficit;
   logic                       w_fits;
   logic                       w_grant;
   logic                       w_advance;

   // Everything the FSM looks at belongs to the port currently being visited.
   always_comb begin
      w_sel_valid   = 1'b0;
      w_sel_size    = '0;
      w_sel_flow    = '0;
      w_sel_deficit = '0;
      for (int p = 0; p < PORT_CNT; p++) begin
         if (r_cur_port == PORT_WIDTH'(p)) begin
            w_sel_valid   = in_valid_i[p];
            w_sel_size    = in_pkt_size_i[p*16 +: 16];
            w_sel_flow    = in_flow_num_i[p*FLOW_CNT_WIDTH +: FLOW_CNT_WIDTH];
            w_sel_deficit = r_deficit[p];
         end
      end
   end

   assign w_visit_sum     = {1'b0, w_sel_deficit} + c_quantum;
   assign w_visit_deficit = w_visit_sum[DEFICIT_WIDTH] ? '1 : w_visit_sum[DEFICIT_WIDTH-1:0];
   assign w_fits          = (w_sel_deficit >= DEFICIT_WIDTH'(w_sel_size));

   always_comb begin
      w_state_nxt = r_state;
      w_grant     = 1'b0;
      w_advance   = 1'b0;
      in_ready_o  = '0;
      case (r_state)
         ST_VISIT: w_state_nxt = ST_SERVE;
         ST_SERVE: begin
            if (w_sel_valid && w_fits) begin
               w_grant     = 1'b1;
               w_state_nxt = ST_SEND;
            end else begin
               w_advance   = 1'b1;
               w_state_nxt = ST_VISIT;
            end
         end
         ST_SEND: begin
            if (task_ready_i) begin
               w_state_nxt = ST_SERVE;
            end
         end
         default: w_state_nxt = ST_VISIT;
      endcase
      for (int p = 0; p < PORT_CNT; p++) begin
         in_ready_o[p] = w_grant && (r_cur_port == PORT_WIDTH'(p));
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state    <= ST_VISIT;
         r_cur_port <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_advance) begin
            r_cur_port <= (r_cur_port == c_last_port) ? '0 : r_cur_port + 1'b1;
         end
      end
   end

   // An idle port forfeits its residual; a blocked port keeps it for its next visit.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int p = 0; p < PORT_CNT; p++) begin
            r_deficit[p] <= '0;
         end
      end else begin
         for (int p = 0; p < PORT_CNT; p++) begin
            if (r_cur_port == PORT_WIDTH'(p)) begin
               if (r_state == ST_VISIT) begin
                  r_deficit[p] <= w_visit_deficit;
               end else if (r_state == ST_SERVE) begin
                  if (!w_sel_valid) begin
                     r_deficit[p] <= '0;
                  end else if (w_grant) begin
                     r_deficit[p] <= w_sel_deficit - DEFICIT_WIDTH'(w_sel_size);
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         task_valid_o    <= 1'b0;
         task_port_o     <= '0;
         task_flow_num_o <= '0;
         task_pkt_size_o <= '0;
      end else if (w_grant) begin
         task_valid_o    <= 1'b1;
         task_port_o     <= r_cur_port;
         task_flow_num_o <= w_sel_flow;
         task_pkt_size_o <= w_sel_size;
      end else if ((r_state == ST_SEND) && task_ready_i) begin
         task_valid_o    <= 1'b0;
      end
   end

`ifdef PKT_GEN_TASK_DRR_ARBITER_STATS_EN
   logic [31:0] r_stat_bytes [PORT_CNT];
   logic [31:0] w_stat_rd;

   always_comb begin
      w_stat_rd = '0;
      for (int p = 0; p < PORT_CNT; p++) begin
         if (stat_rd_port_i == PORT_WIDTH'(p)) begin
            w_stat_rd = r_stat_bytes[p];
         end
      end
   end

   // Clear has priority over a coinciding grant; that grant's bytes are dropped.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int p = 0; p < PORT_CNT; p++) begin
            r_stat_bytes[p] <= '0;
         end
         stat_bytes_o <= '0;
      end else begin
         for (int p = 0; p < PORT_CNT; p++) begin
            if (stat_clr_i) begin
               r_stat_bytes[p] <= '0;
            end else if (w_grant && (r_cur_port == PORT_WIDTH'(p))) begin
               r_stat_bytes[p] <= r_stat_bytes[p] + 32'(w_sel_size);
            end
         end
         stat_bytes_o <= w_stat_rd;
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_pkt_gen_task_drr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_pkt_gen_task_drr_arbiter
// Brief  : Randomized self-checking bench with a queue-level DRR reference.
// Rev    : 1.0
// ============================================================================
module tb_pkt_gen_task_drr_arbiter;

   localparam int PORT_CNT = 4;
   localparam int FW       = 4;
   localparam int QUANTUM  = 1518;
   localparam int DW       = 18;
   localparam int PW       = 2;
   localparam int DEF_MAX  = (1 << DW) - 1;

   typedef struct packed {
      logic [PW-1:0] port;
      logic [FW-1:0] flow;
      logic [15:0]   bytes;
   } task_t;

   logic                    clk_i = 1'b0;
   logic                    rst_i;
   logic [PORT_CNT*FW-1:0]  in_flow_num_i;
   logic [PORT_CNT*16-1:0]  in_pkt_size_i;
   logic [PORT_CNT-1:0]     in_valid_i;
   logic [PORT_CNT-1:0]     in_ready_o;
   logic [PW-1:0]           task_port_o;
   logic [FW-1:0]           task_flow_num_o;
   logic [15:0]             task_pkt_size_o;
   logic                    task_valid_o;
   logic                    task_ready_i;

   task_t src_q [PORT_CNT][$];
   task_t exp_q [$];
   int    acc_cycle [$];
   int    acc_port [$];
   int    granted [PORT_CNT];
   int    total = 0;
   int    bad = 0;

   pkt_gen_task_drr_arbiter #(
      .PORT_CNT       (PORT_CNT),
      .FLOW_CNT_WIDTH (FW),
      .QUANTUM        (QUANTUM),
      .DEFICIT_WIDTH  (DW)
   ) dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .in_flow_num_i   (in_flow_num_i),
      .in_pkt_size_i   (in_pkt_size_i),
      .in_valid_i      (in_valid_i),
      .in_ready_o      (in_ready_o),
      .task_port_o     (task_port_o),
      .task_flow_num_o (task_flow_num_o),
      .task_pkt_size_o (task_pkt_size_o),
      .task_valid_o    (task_valid_o),
      .task_ready_i    (task_ready_i)
   );

   always #5 clk_i = ~clk_i;

   // Textbook DRR over the source queues: visit ports in order, credit a quantum,
   // drain while the head fits, and drop the residual once a queue runs dry.
   task automatic build_expected();
      task_t m_q [PORT_CNT][$];
      int    def [PORT_CNT];
      bit    busy;
      exp_q.delete();
      for (int p = 0; p < PORT_CNT; p++) begin
         m_q[p] = src_q[p];
         def[p] = 0;
      end
      busy = 1'b1;
      while (busy) begin
         busy = 1'b0;
         for (int p = 0; p < PORT_CNT; p++) begin
            if (m_q[p].size() == 0) begin
               def[p] = 0;
            end else begin
               def[p] = (def[p] + QUANTUM > DEF_MAX) ? DEF_MAX : def[p] + QUANTUM;
               while (m_q[p].size() > 0 && int'(m_q[p][0].bytes) <= def[p]) begin
                  exp_q.push_back(m_q[p][0]);
                  def[p] -= int'(m_q[p][0].bytes);
                  void'(m_q[p].pop_front());
               end
               if (m_q[p].size() == 0) def[p] = 0;
               else busy = 1'b1;
            end
         end
      end
   endtask

   task automatic push_task(input int p, input int bytes);
      task_t t;
      t.port  = PW'(p);
      t.flow  = FW'($urandom);
      t.bytes = 16'(bytes);
      src_q[p].push_back(t);
   endtask

   task automatic drive_sources();
      for (int p = 0; p < PORT_CNT; p++) begin
         if (src_q[p].size() > 0) begin
            in_valid_i[p]           = 1'b1;
            in_flow_num_i[p*FW +: FW] = src_q[p][0].flow;
            in_pkt_size_i[p*16 +: 16] = src_q[p][0].bytes;
         end else begin
            in_valid_i[p]           = 1'b0;
            in_flow_num_i[p*FW +: FW] = FW'($urandom);
            in_pkt_size_i[p*16 +: 16] = 16'($urandom);
         end
      end
   endtask

   task automatic apply_reset();
      rst_i        = 1'b1;
      in_valid_i   = '0;
      in_flow_num_i = '0;
      in_pkt_size_i = '0;
      task_ready_i = 1'b0;
      for (int p = 0; p < PORT_CNT; p++) src_q[p].delete();
      exp_q.delete();
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b0;
   endtask

   // Cycle n (n>=1) is the n-th clock after reset release; cycle 0 is the first VISIT.
   task automatic run_traffic(input int budget, input int ready_pct, input int stop_bytes);
      int    pend, prev_acc, sum;
      bit    held, done;
      task_t hold_t, got;
      pend = -1; prev_acc = -1; sum = 0; held = 1'b0; done = 1'b0;
      acc_cycle.delete();
      acc_port.delete();
      for (int p = 0; p < PORT_CNT; p++) granted[p] = 0;
      for (int i = 0; i < budget && !done; i++) begin
         @(posedge clk_i);
         #1;
         if (pend >= 0) begin
            if (src_q[pend].size() > 0) src_q[pend].delete(0);
            pend = -1;
         end
         got = {task_port_o, task_flow_num_o, task_pkt_size_o};
         if (prev_acc >= 0) begin
            total++;
            if (task_valid_o !== 1'b1 || task_port_o !== PW'(prev_acc)) begin
               bad++;
               $display("FAIL latency: valid=%b port=%0d, required valid=1 port=%0d",
                        task_valid_o, task_port_o, prev_acc);
            end
            prev_acc = -1;
         end
         if (held) begin
            total++;
            if (task_valid_o !== 1'b1 || got !== hold_t || in_ready_o !== '0) begin
               bad++;
               $display("FAIL stall_hold: valid=%b task=%h in_ready=%b, required valid=1 task=%h in_ready=0",
                        task_valid_o, got, in_ready_o, hold_t);
            end
            held = 1'b0;
         end
         drive_sources();
         task_ready_i = ($urandom_range(0, 99) < ready_pct);
         #1;
         total++;
         if ($countones(in_ready_o) > 1 || (in_ready_o & ~in_valid_i) !== '0) begin
            bad++;
            $display("FAIL ready_onehot: in_ready=%b in_valid=%b, required at most one ready on a valid port",
                     in_ready_o, in_valid_i);
         end
         for (int p = 0; p < PORT_CNT; p++) begin
            if (in_ready_o[p] === 1'b1 && src_q[p].size() > 0) begin
               pend     = p;
               prev_acc = p;
               acc_cycle.push_back(i + 1);
               acc_port.push_back(p);
               granted[p] += int'(src_q[p][0].bytes);
               sum        += int'(src_q[p][0].bytes);
            end
         end
         if (task_valid_o === 1'b1 && task_ready_i) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL extra_task: got %h, required no further task", got);
            end else begin
               if (got !== exp_q[0]) begin
                  bad++;
                  $display("FAIL task_order: got %h, required %h", got, exp_q[0]);
               end
               void'(exp_q.pop_front());
            end
         end else if (task_valid_o === 1'b1) begin
            held   = 1'b1;
            hold_t = got;
         end
         done = (stop_bytes > 0) ? (sum >= stop_bytes) : (exp_q.size() == 0);
      end
      total++;
      if (!done) begin
         bad++;
         $display("FAIL traffic_timeout: granted=%0d remaining=%0d, required run to complete",
                  sum, exp_q.size());
      end
   endtask

   task automatic test_reset();
      rst_i        = 1'b1;
      in_valid_i   = '1;
      in_flow_num_i = '1;
      in_pkt_size_i = '0;
      task_ready_i = 1'b1;
      repeat (2) @(posedge clk_i);
      #1;
      total++;
      if (in_ready_o !== '0 || task_valid_o !== 1'b0 || task_port_o !== '0 ||
          task_flow_num_o !== '0 || task_pkt_size_o !== '0) begin
         bad++;
         $display("FAIL reset_state: in_ready=%b valid=%b port=%0d flow=%0d size=%0d, required all 0",
                  in_ready_o, task_valid_o, task_port_o, task_flow_num_o, task_pkt_size_o);
      end
   endtask

   task automatic test_idle();
      apply_reset();
      task_ready_i = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk_i);
         #1;
         in_flow_num_i = PORT_CNT*FW'($urandom);
         in_pkt_size_i = {$urandom, $urandom};
         #1;
         total++;
         if (in_ready_o !== '0 || task_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL idle: cycle %0d in_ready=%b valid=%b, required 0 and 0", i, in_ready_o, task_valid_o);
         end
      end
   endtask

   task automatic test_single_port();
      apply_reset();
      for (int k = 0; k < 30; k++) push_task(0, 64);
      build_expected();
      run_traffic(400, 100, 0);
      total++;
      if (acc_cycle.size() != 30) begin
         bad++;
         $display("FAIL single_count: accepts=%0d, required 30", acc_cycle.size());
      end else begin
         total++;
         if (acc_cycle[0] != 1) begin
            bad++;
            $display("FAIL single_first: cycle=%0d, required 1", acc_cycle[0]);
         end
         for (int k = 0; k < 22; k++) begin
            total++;
            if (acc_cycle[k+1] - acc_cycle[k] != 2) begin
               bad++;
               $display("FAIL single_rate: gap %0d = %0d cycles, required 2", k, acc_cycle[k+1] - acc_cycle[k]);
            end
         end
         total++;
         if (acc_cycle[23] - acc_cycle[22] != 10) begin
            bad++;
            $display("FAIL single_credit_out: gap=%0d cycles, required 10", acc_cycle[23] - acc_cycle[22]);
         end
      end
   endtask

   task automatic test_fairness();
      int mx, mn;
      apply_reset();
      for (int k = 0; k < 200; k++) begin
         push_task(0, 64);
         push_task(1, 64);
      end
      for (int k = 0; k < 14; k++) begin
         push_task(2, 1500);
         push_task(3, 1500);
      end
      build_expected();
      run_traffic(5000, 100, 20000);
      mx = granted[0];
      mn = granted[0];
      for (int p = 1; p < PORT_CNT; p++) begin
         if (granted[p] > mx) mx = granted[p];
         if (granted[p] < mn) mn = granted[p];
      end
      total++;
      if (mx - mn > QUANTUM) begin
         bad++;
         $display("FAIL fairness: spread=%0d bytes (%0d/%0d/%0d/%0d), required <= %0d",
                  mx - mn, granted[0], granted[1], granted[2], granted[3], QUANTUM);
      end
   endtask

   task automatic test_back_pressure();
      bit got;
      apply_reset();
      in_valid_i[0]        = 1'b1;
      in_flow_num_i[0 +: FW] = 4'd5;
      in_pkt_size_i[0 +: 16] = 16'd100;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(posedge clk_i);
         #2;
         if (in_ready_o[0] === 1'b1) got = 1'b1;
      end
      total++;
      if (!got) begin
         bad++;
         $display("FAIL stall_accept: no accept within 20 cycles, required one");
      end
      @(posedge clk_i);
      #1;
      in_flow_num_i[0 +: FW] = 4'd6;
      task_ready_i = 1'b0;
      #1;
      for (int i = 0; i < 11; i++) begin
         total++;
         if (task_valid_o !== 1'b1 || task_port_o !== 2'd0 || task_flow_num_o !== 4'd5 ||
             task_pkt_size_o !== 16'd100 || in_ready_o !== '0) begin
            bad++;
            $display("FAIL stall_stable: cycle %0d valid=%b port=%0d flow=%0d size=%0d in_ready=%b, required 1/0/5/100/0",
                     i, task_valid_o, task_port_o, task_flow_num_o, task_pkt_size_o, in_ready_o);
         end
         if (i < 10) begin
            @(posedge clk_i);
            #2;
         end
      end
      task_ready_i = 1'b1;
      @(posedge clk_i);
      #1;
      task_ready_i = 1'b0;
      #1;
      total++;
      if (task_valid_o !== 1'b0 || in_ready_o !== 4'b0001) begin
         bad++;
         $display("FAIL stall_release: valid=%b in_ready=%b, required valid=0 in_ready=0001", task_valid_o, in_ready_o);
      end
      @(posedge clk_i);
      #2;
      total++;
      if (task_valid_o !== 1'b1 || task_flow_num_o !== 4'd6) begin
         bad++;
         $display("FAIL stall_next: valid=%b flow=%0d, required valid=1 flow=6", task_valid_o, task_flow_num_o);
      end
   endtask

   task automatic test_deficit_carry(input int second_bytes, input int second_cycle);
      apply_reset();
      push_task(1, 4000);
      push_task(1, second_bytes);
      build_expected();
      run_traffic(200, 100, 0);
      total++;
      if (acc_cycle.size() != 2) begin
         bad++;
         $display("FAIL deficit_count: accepts=%0d, required 2", acc_cycle.size());
      end else if (acc_cycle[0] != 19 || acc_cycle[1] != second_cycle || acc_port[0] != 1 || acc_port[1] != 1) begin
         bad++;
         $display("FAIL deficit_timing: cycles %0d,%0d ports %0d,%0d, required 19,%0d ports 1,1",
                  acc_cycle[0], acc_cycle[1], acc_port[0], acc_port[1], second_cycle);
      end
   endtask

   task automatic test_reset_mid();
      bit got;
      apply_reset();
      in_valid_i[0]        = 1'b1;
      in_pkt_size_i[0 +: 16] = 16'd64;
      in_flow_num_i[0 +: FW] = 4'd3;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(posedge clk_i);
         #2;
         if (task_valid_o === 1'b1) got = 1'b1;
      end
      total++;
      if (!got) begin
         bad++;
         $display("FAIL reset_mid_setup: no task_valid within 20 cycles, required one");
      end
      rst_i = 1'b1;
      #1;
      total++;
      if (task_valid_o !== 1'b0 || in_ready_o !== '0 || task_pkt_size_o !== '0) begin
         bad++;
         $display("FAIL reset_async: valid=%b in_ready=%b size=%0d, required 0/0/0",
                  task_valid_o, in_ready_o, task_pkt_size_o);
      end
      apply_reset();
      push_task(0, $urandom_range(0, QUANTUM));
      for (int p = 0; p < PORT_CNT; p++) begin
         for (int k = 0; k < 3; k++) push_task(p, $urandom_range(0, 3000));
      end
      build_expected();
      run_traffic(2000, 70, 0);
      total++;
      if (acc_port.size() == 0 || acc_port[0] != 0 || acc_cycle[0] != 1) begin
         bad++;
         $display("FAIL reset_first_grant: accepts=%0d, required first grant from port 0 at cycle 1",
                  acc_port.size());
      end
   endtask

   task automatic test_random();
      for (int r = 0; r < 4; r++) begin
         apply_reset();
         for (int p = 0; p < PORT_CNT; p++) begin
            int n;
            n = $urandom_range(0, 8);
            for (int k = 0; k < n; k++) begin
               push_task(p, ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 4000));
            end
         end
         build_expected();
         run_traffic(6000, $urandom_range(30, 100), 0);
      end
   endtask

   initial begin
      test_reset();
      test_idle();
      test_single_port();
      test_fairness();
      test_back_pressure();
      test_deficit_carry(554, 21);
      test_deficit_carry(555, 29);
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
